// File: rtl/fir_tdm_mac.sv
// -----------------------------------------------------------------------------
// fir_tdm_mac
//   Time-multiplexed FIR filter for CH independent channels sharing one
//   coefficient set and one multiplier. An accepted sample is written into its
//   channel's circular delay line. The filter then performs TAPS multiply-
//   accumulate steps, one per clock. A final cycle rounds, saturates and
//   registers the result.
//
//   Timing for a sample accepted on cycle A:
//     A+1 .. A+TAPS   MAC, taps k = 0..TAPS-1
//     A+TAPS+1        RND (round / saturate, outputs registered)
//     A+TAPS+2        source_valid strobe; the block is ready again
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   sink_valid/ready input handshake; sink_ch selects the channel
//   data_in          signed input sample (DATA_W)
//   coef_we/addr/data coefficient write port; writes are honoured only in IDLE
//   source_valid     one-cycle output strobe
//   source_ch        channel of the output sample (held between strobes)
//   data_out         rounded, saturated output (held between strobes)
//   source_err       [0] saturation on this output
//                    [1] a coefficient write was dropped since the last output
// -----------------------------------------------------------------------------
module fir_tdm_mac #(
    parameter int DATA_W = 14,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 18,
    parameter int TAPS   = 16,
    parameter int CH     = 2,
    parameter int SHIFT  = 14,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1,
    localparam int TAP_W = $clog2(TAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     sink_valid,
    output logic                     sink_ready,
    input  logic [CH_W-1:0]          sink_ch,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     coef_we,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     source_valid,
    output logic [CH_W-1:0]          source_ch,
    output logic signed [OUT_W-1:0]  data_out,
    output logic [1:0]               source_err
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam int DEPTH  = CH * TAPS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS - 1);

    // 2^SHIFT: unity gain at tap 0 after the output shift.
    localparam logic signed [COEF_W-1:0] COEF_UNITY =
        {{(COEF_W-SHIFT-1){1'b0}}, 1'b1, {SHIFT{1'b0}}};

    // Rounding constant 2^(SHIFT-1) and output clamp limits, all at ACC_W+1 bits.
    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        CLR,
        IDLE,
        MAC,
        RND
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0]        clr_cnt_reg;
    logic [TAP_W-1:0]         tap_cnt_reg;
    logic [CH_W-1:0]          ch_reg;
    logic signed [DATA_W-1:0] sample_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     err_coef_reg;

    logic signed [COEF_W-1:0] coef_vec [TAPS];
    logic [TAP_W-1:0]         wp_vec [CH];

    logic [CH_W-1:0] in_ch;
    logic            accept;
    logic            coef_take;
    logic            coef_ignored;

    // Single-channel builds ignore sink_ch entirely.
    assign in_ch        = (CH > 1) ? sink_ch : '0;
    assign accept       = (state_reg == IDLE) && sink_valid;
    assign coef_take    = coef_we && (state_reg == IDLE);
    assign coef_ignored = coef_we && (state_reg != IDLE);

    function automatic logic [ADDR_W-1:0] mem_addr(input logic [CH_W-1:0] c,
                                                   input logic [TAP_W-1:0] p);
        return ADDR_W'({c, p});
    endfunction

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= CLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sink_ready = 1'b0;
        case (state_reg)
            CLR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                sink_ready = 1'b1;
                if (sink_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (tap_cnt_reg == TAP_LAST) begin
                    state_next = RND;
                end
            end
            RND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = CLR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Coefficient registers. These are registers rather than RAM because they
    // need a reset value (the identity filter).
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
            logic signed [COEF_W-1:0] coef_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    coef_q <= (gi == 0) ? COEF_UNITY : '0;
                end else if (coef_take && (coef_addr == TAP_W'(gi))) begin
                    coef_q <= coef_data;
                end
            end
            assign coef_vec[gi] = coef_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-channel write pointers. Each pointer advances when its own sample
    // finishes the last tap.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_wp
            logic [TAP_W-1:0] wp_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    wp_q <= '0;
                end else if ((state_reg == MAC) && (tap_cnt_reg == TAP_LAST) &&
                             (ch_reg == CH_W'(gi))) begin
                    wp_q <= wp_q + TAP_W'(1);
                end
            end
            assign wp_vec[gi] = wp_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Delay-line memory: one write port and one registered read port.
    // The write port either clears the memory (CLR) or stores the accepted
    // sample.
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rd_data_reg;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic signed [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0]        mem_raddr;
    logic [TAP_W-1:0]         rd_ptr;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_reg;
        mem_wdata = '0;
        if (state_reg == CLR) begin
            mem_we = 1'b1;
        end else if (accept) begin
            mem_we    = 1'b1;
            mem_waddr = mem_addr(in_ch, wp_vec[in_ch]);
            mem_wdata = data_in;
        end
    end

    // While tap k is multiplied, tap k+1 is fetched so it arrives in time.
    // Tap 0 is the sample just written, so it comes from sample_reg instead.
    // This avoids a read of the same word in the cycle it is written.
    assign rd_ptr    = wp_vec[ch_reg] - tap_cnt_reg - TAP_W'(1);
    assign mem_raddr = mem_addr(ch_reg, rd_ptr);

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_reg <= mem[mem_raddr];
    end

    // -------------------------------------------------------------------------
    // Datapath: multiply-accumulate, rounding and saturation
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] mac_operand;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    rnd_shift;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [OUT_W-1:0]  rnd_out;

    assign mac_operand = (tap_cnt_reg == '0) ? sample_reg : rd_data_reg;
    assign prod        = PROD_W'(coef_vec[tap_cnt_reg]) * PROD_W'(mac_operand);
    assign acc_next    = acc_reg + ACC_W'(prod);

    // Adding half an LSB and then flooring rounds half toward +inf.
    assign rnd_sum   = (ACC_W+1)'(acc_reg) + RND_HALF;
    assign rnd_shift = rnd_sum >>> SHIFT;
    assign sat_hi    = rnd_shift > OUT_MAX;
    assign sat_lo    = rnd_shift < OUT_MIN;

    always_comb begin
        rnd_out = rnd_shift[OUT_W-1:0];
        if (sat_hi) begin
            rnd_out = OUT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            rnd_out = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_cnt_reg  <= '0;
            tap_cnt_reg  <= '0;
            ch_reg       <= '0;
            sample_reg   <= '0;
            acc_reg      <= '0;
            err_coef_reg <= 1'b0;
            source_valid <= 1'b0;
            source_ch    <= '0;
            data_out     <= '0;
            source_err   <= '0;
        end else begin
            source_valid <= 1'b0;

            if (state_reg == CLR) begin
                clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
            end

            if (accept) begin
                ch_reg      <= in_ch;
                sample_reg  <= data_in;
                acc_reg     <= '0;
                tap_cnt_reg <= '0;
            end

            // The tap counter wraps to 0 after the last tap.
            if (state_reg == MAC) begin
                acc_reg     <= acc_next;
                tap_cnt_reg <= tap_cnt_reg + TAP_W'(1);
            end

            // The dropped-write flag is reported with the output and then
            // cleared. A write dropped in the RND cycle itself is still
            // reported with this output.
            if (state_reg == RND) begin
                source_valid <= 1'b1;
                source_ch    <= ch_reg;
                data_out     <= rnd_out;
                source_err   <= {err_coef_reg | coef_ignored, sat_hi | sat_lo};
                err_coef_reg <= 1'b0;
            end else if (coef_ignored) begin
                err_coef_reg <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fir_tdm_mac.md
Name: fir_tdm_mac

Overview:
- Parametrised successor to the single-channel myFIR block used in the FOG/PIG signal chain.
- Time-multiplexed FIR filter, CH channels, each with its own delay line; one shared multiplier, one multiply-accumulate (MAC) per clock.
- Coefficients are runtime-programmable. Output is rounded and saturated, with error flags.
- Sits between the ADC sample path and the demodulator; sink/source handshake matches the existing FIR interface.

Parameters:
- DATA_W, 14: signed input sample width.
- COEF_W, 16: signed coefficient width.
- OUT_W, 18: signed output width.
- TAPS, 16: filter length (power of 2, >= 2).
- CH, 2: channel count (power of 2, >= 1).
- SHIFT, 14: output right-shift, 1 <= SHIFT < COEF_W-1.

Ports:
- i_clk, in, 1: clock; all logic on rising edge.
- i_rst, in, 1: synchronous reset, active-high.
- sink_valid, in, 1: input sample valid.
- sink_ready, out, 1: block can accept a sample.
- sink_ch, in, clog2(CH) (min 1): channel of input sample.
- data_in, in, DATA_W: signed input sample.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, clog2(TAPS): tap index to write.
- coef_data, in, COEF_W: signed coefficient value.
- source_valid, out, 1: one-cycle output strobe.
- source_ch, out, clog2(CH) (min 1): channel of the output sample.
- data_out, out, OUT_W: signed filtered sample.
- source_err, out, 2: [0] saturation on this output; [1] coefficient write ignored since the previous output.

Behaviour:
- One clock domain, i_clk.
- Reset is synchronous and active-high on i_rst.
- Reset state:
  - FSM goes to CLR.
  - sink_ready=0, source_valid=0, data_out=0, source_ch=0, source_err=0.
  - All channel write pointers = 0.
  - Coefficients reset to c[0]=2^SHIFT, c[k>0]=0, i.e. identity pass-through.
- FSM states: CLR, IDLE, MAC, RND.
- CLR:
  - Zeroes the delay-line memory (CH*TAPS words), one word per cycle.
  - Lasts exactly CH*TAPS cycles, then goes to IDLE.
  - sink_ready=0 throughout.
- IDLE:
  - sink_ready=1.
  - Handshake when sink_valid & sink_ready, on cycle A:
    - data_in is written to mem[sink_ch][wp[sink_ch]].
    - Channel is latched; accumulator is cleared; FSM goes to MAC.
  - sink_valid while sink_ready=0 is not accepted; upstream must hold.
- MAC:
  - Runs TAPS cycles, k = 0..TAPS-1.
  - Each cycle: acc += c[k] * mem[ch][(wp[ch]-k) mod TAPS], with wrap-around modulo TAPS.
  - After the last tap: wp[ch] increments modulo TAPS; FSM goes to RND.
- Arithmetic:
  - Products are full-precision signed (DATA_W+COEF_W bits).
  - acc is DATA_W+COEF_W+clog2(TAPS) bits signed and never overflows.
- RND, one cycle:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift; round half toward +inf).
  - If r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1), clamp to the limit and set source_err[0]=1; otherwise source_err[0]=0.
  - Register data_out and source_ch, pulse source_valid=1, return to IDLE.
- Latency: accept on cycle A gives source_valid on cycle A+TAPS+2.
  - Throughput is one sample per TAPS+2 cycles.
  - sink_ready is low from A+1 through A+TAPS+1 and high again on A+TAPS+2.
- data_out and source_ch hold their values between strobes. source_valid lasts exactly one cycle.
- Coefficient writes:
  - Accepted only when FSM=IDLE. The write takes effect for the next accepted sample.
  - A coef_we in the same cycle as an accepted sample writes first; the new coefficient is used by that sample.
  - coef_we in CLR, MAC or RND is ignored and sets a sticky flag. The flag appears on source_err[1] at the next output strobe and is cleared after that strobe.
- Channels are fully independent: separate delay lines and pointers, shared coefficients.
- i_rst asserted mid-MAC or mid-RND:
  - Computation is aborted; no source_valid is produced.
  - Coefficients return to reset values.
  - FSM re-runs CLR.

Test Plan:
- Reset, then count cycles -> sink_ready low for exactly 32 cycles (CH=2, TAPS=16) after i_rst deasserts, then 1.
- Default coefficients: data_in=1000 on ch0 accepted at cycle A -> source_valid at A+18 with data_out=1000, source_ch=0, source_err=0; repeat with -1000 -> -1000.
- Impulse response:
  - Load c[k]=100*k.
  - On ch1, input 16384-clipped impulse: data_in=4096, then 15 zeros.
  - Expected data_out sequence: 25*k, k=0..15.
  - ch0 outputs interleaved with it stay 0 for zero input.
- Saturation: all c[k]=32767, constant data_in=8191 on ch0 -> after the 16th sample data_out=131071 and source_err[0]=1; data_in=-8192 long enough -> -131072, err[0]=1.
- Ignored write: coef_we pulsed during MAC -> coefficient unchanged and source_err[1]=1 on that output only; it returns to 0 on the next output.
- Mid-operation reset, plus sine run:
  - i_rst pulsed at A+5 -> no source_valid, CLR repeated, identity response afterwards.
  - 10 kHz sine, amplitude 8191, 500 points/period, on both channels with identity coefficients -> output matches input exactly.
